// File: rtl/dsp_mult_add_slice_if.sv
// Operand, control and result bundle for one multiply-add slice.
// The master drives operands and enables; the slave returns p and pcout.
interface dsp_mult_add_slice_if;
  logic        cea;
  logic        ceb;
  logic        cec;
  logic        cem;
  logic        cep;
  logic        cectrl;
  logic [6:0]  opmode;
  logic [3:0]  alumode;
  logic        carryin;
  logic [24:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [47:0] pcin;
  logic [47:0] p;
  logic [47:0] pcout;

  modport master (
    output cea, ceb, cec, cem, cep, cectrl, opmode, alumode, carryin, a, b, c, pcin,
    input  p, pcout
  );

  modport slave (
    input  cea, ceb, cec, cem, cep, cectrl, opmode, alumode, carryin, a, b, c, pcin,
    output p, pcout
  );
endinterface

// File: rtl/dsp_mult_add_slice.sv
// Multiply-accumulate slice P = Z +/- (X + Y + carryin), every stage optionally registered.
// Latency a/b->p = (AREG|BREG)+MREG+PREG, c->p = CREG+PREG; no backpressure, clock enables stall stages.
module dsp_mult_add_slice #(
  parameter bit AREG      = 1'b0,
  parameter bit BREG      = 1'b0,
  parameter bit CREG      = 1'b0,
  parameter bit MREG      = 1'b0,
  parameter bit PREG      = 1'b0,
  parameter bit OPMODEREG = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  dsp_mult_add_slice_if.slave bus
);

  logic [24:0] a_q, a_s;
  logic [17:0] b_q, b_s;
  logic [47:0] c_q, c_s;
  logic [11:0] ctrl_d, ctrl_q, ctrl_s;
  logic [42:0] m_d, m_q, m_s;
  logic [47:0] p_q, p_fb, m_ext, x_v, y_v, z_v, s_v, alu_v, p_v;
  logic [6:0]  opmode;
  logic [3:0]  alumode;
  logic        carryin;

  assign ctrl_d = {bus.opmode, bus.alumode, bus.carryin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      ctrl_q <= '0;
      m_q    <= '0;
      p_q    <= '0;
    end else begin
      if (bus.cea)    a_q    <= bus.a;
      if (bus.ceb)    b_q    <= bus.b;
      if (bus.cec)    c_q    <= bus.c;
      if (bus.cectrl) ctrl_q <= ctrl_d;
      if (bus.cem)    m_q    <= m_d;
      if (bus.cep)    p_q    <= alu_v;
    end
  end

  // Unused stages stay in the netlist but are bypassed; synthesis trims them.
  assign a_s    = AREG      ? a_q    : bus.a;
  assign b_s    = BREG      ? b_q    : bus.b;
  assign c_s    = CREG      ? c_q    : bus.c;
  assign ctrl_s = OPMODEREG ? ctrl_q : ctrl_d;
  assign {opmode, alumode, carryin} = ctrl_s;

  // Sign-extend both operands to the product width so the low 43 bits are the signed product.
  assign m_d   = {{18{a_s[24]}}, a_s} * {{25{b_s[17]}}, b_s};
  assign m_s   = MREG ? m_q : m_d;
  assign m_ext = {{5{m_s[42]}}, m_s};

  // Without a P register there is nothing to feed back; zero avoids a combinational loop.
  assign p_fb = PREG ? p_q : '0;

  always_comb begin
    x_v = '0;
    case (opmode[1:0])
      2'b01:   if (opmode[3:2] == 2'b01) x_v = m_ext;
      2'b10:   x_v = p_fb;
      2'b11:   x_v = {5'b0, a_s, b_s};
      default: x_v = '0;
    endcase

    y_v = '0;
    case (opmode[3:2])
      2'b10:   y_v = '1;
      2'b11:   y_v = c_s;
      default: y_v = '0;
    endcase

    z_v = '0;
    case (opmode[6:4])
      3'b001:  z_v = bus.pcin;
      3'b010:  z_v = p_fb;
      3'b011:  z_v = c_s;
      3'b101:  z_v = $signed(bus.pcin) >>> 17;
      3'b110:  z_v = $signed(p_fb) >>> 17;
      default: z_v = '0;
    endcase

    s_v = x_v + y_v + {47'd0, carryin};

    alu_v = z_v + s_v;
    case (alumode)
      4'b0011: alu_v = z_v - s_v;
      4'b0001: alu_v = ~z_v + s_v;
      4'b0010: alu_v = ~(z_v + s_v);
      default: alu_v = z_v + s_v;
    endcase
  end

  assign p_v       = PREG ? p_q : alu_v;
  assign bus.p     = p_v;
  assign bus.pcout = p_v;

endmodule

// File: tb/tb_dsp_mult_add_slice.sv
// Checks a combinational and a fully pipelined slice against an arithmetic reference model.
module tb_dsp_mult_add_slice;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  dsp_mult_add_slice_if ifc_c ();
  dsp_mult_add_slice_if ifc_p ();

  dsp_mult_add_slice u_comb (.clk(clk), .rst_n(rst_n), .bus(ifc_c));

  dsp_mult_add_slice #(
    .AREG(1'b1), .BREG(1'b1), .CREG(1'b1), .MREG(1'b1), .PREG(1'b1), .OPMODEREG(1'b1)
  ) u_pipe (.clk(clk), .rst_n(rst_n), .bus(ifc_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: operands for the product and for the {a,b} concatenation are passed separately
  // so the pipelined slice can be modelled with the stage each one comes from.
  function automatic logic [47:0] ref_p(input logic [24:0] ma, input logic [17:0] mb,
                                        input logic [24:0] xa, input logic [17:0] xb,
                                        input logic [47:0] cv, input logic [47:0] pc,
                                        input logic [6:0] op, input logic [3:0] am,
                                        input logic ci, input logic [47:0] pfb);
    longint prod, xv, yv, zv, s, r;
    prod = longint'($signed(ma)) * longint'($signed(mb));
    case (op[1:0])
      2'd1:    xv = (op[3:2] == 2'd1) ? prod : 0;
      2'd2:    xv = longint'(pfb);
      2'd3:    xv = longint'({xa, xb});
      default: xv = 0;
    endcase
    case (op[3:2])
      2'd2:    yv = (longint'(1) <<< 48) - 1;
      2'd3:    yv = longint'(cv);
      default: yv = 0;
    endcase
    case (op[6:4])
      3'd1:    zv = longint'(pc);
      3'd2:    zv = longint'(pfb);
      3'd3:    zv = longint'(cv);
      3'd5:    zv = longint'($signed(pc)) >>> 17;
      3'd6:    zv = longint'($signed(pfb)) >>> 17;
      default: zv = 0;
    endcase
    s = xv + yv + longint'(ci);
    case (am)
      4'd3:    r = zv - s;
      4'd1:    r = s - zv - 1;
      4'd2:    r = -(zv + s) - 1;
      default: r = zv + s;
    endcase
    return r[47:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic [24:0] a, input logic [17:0] b, input logic [47:0] c,
                         input logic [47:0] pc, input logic [6:0] op, input logic [3:0] am,
                         input logic ci);
    @(negedge clk);
    ifc_c.a = a; ifc_c.b = b; ifc_c.c = c; ifc_c.pcin = pc;
    ifc_c.opmode = op; ifc_c.alumode = am; ifc_c.carryin = ci;
    #1;
  endtask

  logic [24:0] ra, a1, a2;
  logic [17:0] rb, b1, b2;
  logic [47:0] rc, rpc, c1, pprev, exp_p;
  logic [6:0]  rop, op1;
  logic [3:0]  ram, am1;
  logic        rci, ci1;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    {ifc_c.cea, ifc_c.ceb, ifc_c.cec, ifc_c.cem, ifc_c.cep, ifc_c.cectrl} = 6'b111111;
    {ifc_p.cea, ifc_p.ceb, ifc_p.cec, ifc_p.cem, ifc_p.cep, ifc_p.cectrl} = 6'b111111;
    ifc_c.a = '0; ifc_c.b = '0; ifc_c.c = '0; ifc_c.pcin = '0;
    ifc_c.opmode = '0; ifc_c.alumode = '0; ifc_c.carryin = 1'b0;
    ifc_p.a = '0; ifc_p.b = '0; ifc_p.c = 48'd1000; ifc_p.pcin = '0;
    ifc_p.opmode = 7'b0110101; ifc_p.alumode = '0; ifc_p.carryin = 1'b0;

    // Combinational slice, directed cases
    drive_c(25'd0, -18'sd32768, 48'd5, 48'd0, 7'b0110101, 4'b0000, 1'b0);
    check("comb_zero_a", ifc_c.p, 48'd5);
    drive_c(25'd3, -18'sd2, 48'd10, 48'd0, 7'b0110101, 4'b0000, 1'b0);
    check("comb_neg_b", ifc_c.p, 48'd4);
    drive_c(-25'sd16777216, -18'sd131072, 48'd0, 48'd0, 7'b0110101, 4'b0000, 1'b0);
    check("comb_max_prod", ifc_c.p, 48'h0200_0000_0000);
    drive_c(25'd4, 18'd5, 48'd100, 48'd0, 7'b0110101, 4'b0011, 1'b0);
    check("comb_sub", ifc_c.p, 48'd80);
    drive_c(25'd0, 18'd0, 48'd0, 48'd0, 7'b0110101, 4'b0010, 1'b0);
    check("comb_not_sum", ifc_c.p, 48'hFFFF_FFFF_FFFF);
    drive_c(-25'sd1, 18'd0, 48'd0, 48'd0, 7'b0000011, 4'b0000, 1'b0);
    check("comb_concat", ifc_c.p, 48'h07FF_FFFC_0000);
    drive_c(25'd3, 18'd5, 48'd7, 48'd0, 7'b0110001, 4'b0000, 1'b0);
    check("comb_illegal_m", ifc_c.p, 48'd7);
    drive_c(25'd0, 18'd0, 48'd0, 48'h8000_0000_0000, 7'b1011000, 4'b0000, 1'b1);
    check("comb_pcin_shift", ifc_c.p, 48'hFFFF_C000_0000);
    drive_c(25'd0, 18'd0, 48'd10, 48'd0, 7'b0110000, 4'b0001, 1'b1);
    check("comb_inv_z", ifc_c.p, 48'hFFFF_FFFF_FFF6);
    drive_c(25'd0, 18'd0, 48'd6, 48'd0, 7'b0111100, 4'b0101, 1'b0);
    check("comb_other_alu", ifc_c.p, 48'd12);
    check("comb_pcout", ifc_c.pcout, 48'd12);

    // Combinational slice, random operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = 25'($urandom); rb = 18'($urandom);
      rc = {16'($urandom), 32'($urandom)}; rpc = {16'($urandom), 32'($urandom)};
      rop = 7'($urandom); ram = 4'($urandom_range(0, 4)); rci = 1'($urandom);
      drive_c(ra, rb, rc, rpc, rop, ram, rci);
      check("comb_rand", ifc_c.p, ref_p(ra, rb, ra, rb, rc, rpc, rop, ram, rci, 48'd0));
    end

    // Pipelined slice: reset state, c latency, a/b latency, enable holds
    check("pipe_reset_p", ifc_p.p, 48'd0);
    check("pipe_reset_pcout", ifc_p.pcout, 48'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    check("pipe_c_latency", ifc_p.p, 48'd1000);
    @(negedge clk); ifc_p.a = 25'd7; ifc_p.b = 18'd9;
    tick(); check("pipe_ab_cyc1", ifc_p.p, 48'd1000);
    tick(); check("pipe_ab_cyc2", ifc_p.p, 48'd1000);
    tick(); check("pipe_ab_cyc3", ifc_p.p, 48'd1063);
    @(negedge clk); ifc_p.a = 25'd2; ifc_p.b = 18'd2; ifc_p.cem = 1'b0;
    tick(); tick(); tick();
    check("pipe_cem_hold", ifc_p.p, 48'd1063);
    @(negedge clk); ifc_p.cem = 1'b1;
    tick(); tick();
    check("pipe_cem_resume", ifc_p.p, 48'd1004);
    @(negedge clk); ifc_p.cep = 1'b0; ifc_p.c = 48'd5;
    tick(); tick(); tick();
    check("pipe_cep_hold", ifc_p.p, 48'd1004);
    @(negedge clk); ifc_p.cep = 1'b1;
    tick();
    check("pipe_cep_resume", ifc_p.p, 48'd9);

    // Accumulate P + a*b
    @(negedge clk);
    rst_n = 1'b0;
    ifc_p.a = 25'd2; ifc_p.b = 18'd3; ifc_p.c = 48'd0; ifc_p.opmode = 7'b0100101;
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    check("acc_fill", ifc_p.p, 48'd0);
    tick(); check("acc_step1", ifc_p.p, 48'd6);
    tick(); check("acc_step2", ifc_p.p, 48'd12);
    tick(); check("acc_step3", ifc_p.p, 48'd18);

    // Asynchronous reset between edges, held across an enabled edge
    #1 rst_n = 1'b0;
    #1 check("async_reset", ifc_p.p, 48'd0);
    ifc_p.a = 25'd7; ifc_p.b = 18'd9; ifc_p.opmode = 7'b0110101;
    tick();
    check("reset_beats_ce", ifc_p.p, 48'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(); check("refill_cyc1", ifc_p.p, 48'd0);
    tick(); check("refill_cyc2", ifc_p.p, 48'd0);
    tick(); check("refill_cyc3", ifc_p.p, 48'd63);

    // Pipelined slice, random stream against a stage-delayed model
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    a1 = '0; a2 = '0; b1 = '0; b2 = '0; c1 = '0; op1 = '0; am1 = '0; ci1 = 1'b0; pprev = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ra = 25'($urandom); rb = 18'($urandom);
      rc = {16'($urandom), 32'($urandom)}; rpc = {16'($urandom), 32'($urandom)};
      rop = 7'($urandom); ram = 4'($urandom_range(0, 4)); rci = 1'($urandom);
      ifc_p.a = ra; ifc_p.b = rb; ifc_p.c = rc; ifc_p.pcin = rpc;
      ifc_p.opmode = rop; ifc_p.alumode = ram; ifc_p.carryin = rci;
      exp_p = ref_p(a2, b2, a1, b1, c1, rpc, op1, am1, ci1, pprev);
      tick();
      check("pipe_rand", ifc_p.p, exp_p);
      if (i % 10 == 0) check("pipe_rand_pcout", ifc_p.pcout, exp_p);
      pprev = exp_p;
      a2 = a1; b2 = b1; a1 = ra; b1 = rb;
      c1 = rc; op1 = rop; am1 = ram; ci1 = rci;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
